// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 shared mux path with a bounded hold time.
// Grants, select and busy are all registered; req has no combinational path to outputs.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold;

  logic [7:0] cand;
  logic       found;
  logic [2:0] pick;
  logic [2:0] idx;

  // The current holder is masked out so a handoff or preemption never re-grants it.
  always_comb begin
    cand  = (state == GRANT) ? (req & ~gnt) : req;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= 8'b1 << pick;
            sel   <= pick;
            busy  <= 1'b1;
            ptr   <= pick + 3'd1;
            hold  <= 8'd1;
          end
        end
        GRANT: begin
          if (req[sel] && (hold < HOLD_MAX)) begin
            hold <= hold + 8'd1;
          end else if (found) begin
            // Release with other requesters pending, or hold limit reached: hand off.
            gnt  <= 8'b1 << pick;
            sel  <= pick;
            ptr  <= pick + 3'd1;
            hold <= 8'd1;
          end else if (!req[sel]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            hold  <= '0;
          end
          // Otherwise the holder keeps the grant alone with hold saturated.
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          hold  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed literal checks plus a per-cycle
// comparison against a queue-free round-robin reference model.
module tb_mux8_rr_arbiter;

  localparam int MH    = 8;
  localparam int BOUND = 7 * MH + 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: holder index (-1 = nobody), cycles held, rr start point, last select.
  int m_h = -1;
  int m_c = 0;
  int m_p = 0;
  int m_s = 0;
  int waitc [8];

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input int start, input logic [7:0] r, input int excl);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (start + i) % 8;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic take(input int k);
    m_h = k;
    m_s = k;
    m_c = 1;
    m_p = (k + 1) % 8;
  endtask

  task automatic model_step(input logic [7:0] r);
    int nxt;
    if (m_h < 0) begin
      nxt = first_from(m_p, r, -1);
      if (nxt >= 0) take(nxt);
    end else begin
      nxt = first_from(m_p, r, m_h);
      if (r[m_h] && (m_c < MH || nxt < 0)) begin
        if (m_c < MH) m_c++;
      end else if (nxt >= 0) begin
        take(nxt);
      end else begin
        m_h = -1;
      end
    end
  endtask

  function automatic logic [7:0] model_gnt();
    logic [7:0] g;
    g = '0;
    if (m_h >= 0) g[m_h] = 1'b1;
    return g;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_h = -1; m_c = 0; m_p = 0; m_s = 0;
      end else begin
        model_step(req);
      end
    end
  end

  // Per-cycle compare against the model, plus starvation bound.
  initial begin
    for (int k = 0; k < 8; k++) waitc[k] = 0;
    forever begin
      int worst;
      @(negedge clk);
      chk("model_gnt",  {24'd0, gnt}, {24'd0, model_gnt()});
      chk("model_sel",  {29'd0, sel}, 32'(m_s));
      chk("model_busy", {31'd0, busy}, {31'd0, (m_h >= 0)});
      chk("onehot0",    {31'd0, ($countones(gnt) <= 1)}, 32'd1);
      worst = 0;
      for (int k = 0; k < 8; k++) begin
        if (rst_n && req[k] && !gnt[k]) waitc[k]++;
        else waitc[k] = 0;
        if (waitc[k] > worst) worst = waitc[k];
      end
      chk("starve", {31'd0, (worst <= BOUND)}, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #2;
    chk("rst_gnt",  {24'd0, gnt}, 32'h00);
    chk("rst_sel",  {29'd0, sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    #1;
    do_reset();

    // Hold limit with wrap: 0 -> 7 -> 0.
    req = 8'h81;
    step();
    chk("hl_g0", {24'd0, gnt}, 32'h01);
    chk("hl_s0", {29'd0, sel}, 32'd0);
    repeat (7) step();
    chk("hl_g0_last", {24'd0, gnt}, 32'h01);
    step();
    chk("hl_g7", {24'd0, gnt}, 32'h80);
    chk("hl_s7", {29'd0, sel}, 32'd7);
    repeat (7) step();
    chk("hl_g7_last", {24'd0, gnt}, 32'h80);
    step();
    chk("hl_wrap", {24'd0, gnt}, 32'h01);

    // Single requester then release to idle; sel holds.
    do_reset();
    req = 8'h04;
    step();
    chk("sr_g", {24'd0, gnt}, 32'h04);
    chk("sr_s", {29'd0, sel}, 32'd2);
    chk("sr_b", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("sr_g3", {24'd0, gnt}, 32'h04);
    req = 8'h00;
    step();
    chk("sr_idle_g", {24'd0, gnt}, 32'h00);
    chk("sr_idle_b", {31'd0, busy}, 32'd0);
    chk("sr_idle_s", {29'd0, sel}, 32'd2);
    step();
    chk("sr_idle_s2", {29'd0, sel}, 32'd2);

    // Release with another pending: handoff with no bubble.
    do_reset();
    req = 8'h14;
    step();
    chk("ho_g2", {24'd0, gnt}, 32'h04);
    step();
    chk("ho_g2b", {24'd0, gnt}, 32'h04);
    req = 8'h10;
    step();
    chk("ho_g4", {24'd0, gnt}, 32'h10);
    chk("ho_s4", {29'd0, sel}, 32'd4);
    chk("ho_busy", {31'd0, busy}, 32'd1);

    // Lone requester never preempted.
    do_reset();
    req = 8'h20;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lone_g", {24'd0, gnt}, 32'h20);
    end

    // Async reset mid-grant, then all requesting: first grant is 0.
    do_reset();
    req = 8'hFF;
    step();
    chk("ar_g0", {24'd0, gnt}, 32'h01);
    step();
    chk("ar_g0b", {24'd0, gnt}, 32'h01);
    rst_n = 1'b0;
    #2;
    chk("ar_gnt",  {24'd0, gnt}, 32'h00);
    chk("ar_sel",  {29'd0, sel}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_first", {24'd0, gnt}, 32'h01);

    // Random traffic with sticky request bits.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic [7:0] r;
      r = req;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 9) == 0) r[k] = ~r[k];
      req = r;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
